// File: rtl/audio_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_pacer
// Description : Sample-rate pacing FIFO. The bus side pushes 8-bit unsigned
//               audio samples; a programmable divider pops one sample per
//               period and presents it with a one-cycle strobe. On underrun
//               the block emits silence (128) and keeps the cadence.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_pacer #(
  parameter int DEPTH     = 256,
  parameter int LOW_WATER = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     enable,
  input  logic [15:0]              div,
  input  logic                     clr_underrun,
  output logic [7:0]               sample_out,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic                     low_water
);

  localparam int                   ADDR_W        = $clog2(DEPTH);
  localparam int                   LEVEL_W       = ADDR_W + 1;
  localparam logic [7:0]           SILENCE       = 8'h80;
  localparam logic [LEVEL_W-1:0]   DEPTH_LVL     = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0]   LOW_WATER_LVL = LEVEL_W'(LOW_WATER);
  localparam logic [LEVEL_W-1:0]   LEVEL_ONE     = LEVEL_W'(1);
  localparam logic [ADDR_W-1:0]    PTR_ONE       = ADDR_W'(1);

  // Sample storage; no reset so it can map onto block RAM.
  logic [7:0]          mem [DEPTH];

  // Registered state.
  logic [15:0]         cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [LEVEL_W-1:0]  level_q,     level_d;
  logic [7:0]          sample_q,    sample_d;
  logic                strobe_q,    strobe_d;
  logic                underrun_q,  underrun_d;
  logic                low_water_q, low_water_d;

  // Combinational control.
  logic                w_push;
  logic                w_tick;
  logic                w_empty;
  logic                w_pop;
  logic [7:0]          w_rd_data;

  // Handshake and tick decisions for this cycle.
  always_comb begin
    w_push    = wr_valid && (level_q != DEPTH_LVL);
    w_tick    = enable && (cnt_q >= div);
    w_empty   = (level_q == '0);
    w_pop     = w_tick && !w_empty;
    w_rd_data = mem[rd_ptr_q];
  end

  // Next-state logic for divider, pointers, occupancy and output registers.
  always_comb begin
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    sample_d    = sample_q;
    strobe_d    = 1'b0;
    underrun_d  = underrun_q;
    low_water_d = enable && (level_q < LOW_WATER_LVL);

    // Divider: held at zero while disabled; >= lets a lowered div act at once.
    if (!enable || w_tick) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    // Every tick strobes; an empty FIFO yields silence instead of stalling.
    if (w_tick) begin
      strobe_d = 1'b1;
      sample_d = w_empty ? SILENCE : w_rd_data;
    end else if (!enable) begin
      sample_d = SILENCE;
    end

    // A new underrun outranks a simultaneous clear request.
    if (w_tick && w_empty) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 16'd0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      sample_q    <= SILENCE;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
      low_water_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      sample_q    <= sample_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
      low_water_q <= low_water_d;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready      = (level_q != DEPTH_LVL);
  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign level         = level_q;
  assign underrun      = underrun_q;
  assign low_water     = low_water_q;

endmodule
`default_nettype wire

// File: doc/audio_sample_pacer.md
# audio_sample_pacer

Sample-rate pacing FIFO that sits directly upstream of the audio visualizer and the audio output stage. The CPU bus side pushes 8-bit unsigned audio samples (midpoint 128) into an internal FIFO. A programmable rate divider pops exactly one sample per sample period and presents it with a one-cycle strobe. The strobe drives the visualizer's enable and the DAC's sample-load. On underrun the block emits silence (128) and keeps the sample cadence, so downstream stages never stall.

## Interface
- `DEPTH`, 256, FIFO depth in samples; must be a power of two, at least 4.
- `LOW_WATER`, 64, refill threshold in samples; must satisfy 1 ≤ LOW_WATER ≤ DEPTH.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `wr_data`  in  8  sample to push.
- `wr_valid`  in  1  push request.
- `wr_ready`  out  1  combinational `level != DEPTH`; a push occurs when `wr_valid && wr_ready`.
- `enable`  in  1  playback enable.
- `div`  in  16  sample period minus one, in clk cycles; sampled every cycle.
- `clr_underrun`  in  1  clears the sticky `underrun` flag.
- `sample_out`  out  8  current sample, registered.
- `sample_strobe`  out  1  one-cycle pulse; `sample_out` updated this cycle.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy, registered, range 0..DEPTH.
- `underrun`  out  1  sticky: a tick found the FIFO empty.
- `low_water`  out  1  registered: `enable && level < LOW_WATER`.

## Operation
- **Storage.** `DEPTH`×8 array with `rd_ptr`/`wr_ptr` of clog2(DEPTH) bits. Pointers wrap modulo `DEPTH`. `level` is an explicit counter. Reads are synchronous so the array maps to block RAM.
- **Push.** A push writes `mem[wr_ptr]` and increments `wr_ptr`. A push with `level == DEPTH` is impossible, because `wr_ready` is low. There is no overflow state.
- **Rate counter `cnt` (16 bits).**
  - When `enable` is 0, `cnt` is held at 0 and no ticks occur.
  - When `enable` is 1 and `cnt >= div`: tick, and `cnt` becomes 0.
  - Otherwise `cnt` increments by 1.
  - The tick period is `div+1` cycles; `div=0` gives a tick every cycle.
  - Using `>=` makes a mid-period decrease of `div` take effect within at most one cycle, with no wrap through 65535.
- **Tick with `level > 0`.** `sample_out` takes `mem[rd_ptr]`, `rd_ptr` increments, `level` decrements.
- **Tick with `level == 0`.** `sample_out` becomes 128 and `underrun` is set. Pointers and `level` are unchanged.
- **Strobe on every tick.** `sample_strobe` pulses on every tick, including underrun ticks, so the downstream cadence is constant.
- **Push and pop in the same cycle.** `level` is unchanged and both pointers advance.
- **Push into an empty FIFO in a tick cycle.** There is no fall-through: the tick underruns, and the pushed sample remains in the FIFO for the next tick.
- **`enable` falling.**
  - On the next edge `sample_out` becomes 128, `sample_strobe` is 0 and `cnt` is 0.
  - FIFO contents, pointers and `underrun` are retained.
  - Pushes remain allowed while disabled (pre-fill).
- **`enable` rising.** The first tick occurs `div+1` edges after the first edge at which `enable` is high.
- **`underrun` set versus clear.** If `clr_underrun` and a new underrun tick occur in the same cycle, set wins.

## Timing
- **Reset values** (applied immediately on `rst` rising, no clock needed):
  - `sample_out`=128, `sample_strobe`=0, `level`=0, `underrun`=0, `low_water`=0.
  - `cnt`, `rd_ptr` and `wr_ptr` are 0.
  - `wr_ready` reads 1.
  - Array contents are don't-care.
- **Reset mid-operation** discards all buffered samples. There is no partial-state recovery.
- **Tick latency.** A tick decided at edge N (using `cnt` before edge N) produces `sample_out` and `sample_strobe` valid after edge N. The strobe is high for exactly one cycle.
- **Push-to-level latency.** A push at edge N is reflected in `level` and `wr_ready` after edge N. A popped sample is readable at the earliest on a tick one edge after its push.
- **`low_water`** lags `level` by one cycle.

## Test plan
- **Reset.** Assert `rst` asynchronously between edges → immediately `sample_out`=0x80, `sample_strobe`=0, `level`=0, `underrun`=0, `low_water`=0, `wr_ready`=1.
- **Cadence and underrun.** `div`=3, `enable`=1, push 0x10, 0x20, 0x30 while disabled, then enable → strobes exactly every 4 cycles carrying 0x10, 0x20, 0x30. The fourth strobe carries 0x80 with `underrun`=1, and `level` steps 3→2→1→0.
- **Full and in-order drain.** With `enable`=0, push 257 samples (value i mod 256) → `level`=256, `wr_ready`=0, the 257th is not accepted. Then `div`=0, `enable`=1 → 256 consecutive strobes with data 0..255 in order, then 0x80 with `underrun`=1.
- **Simultaneous push and pop.** At `level`=5, push in a tick cycle → `level` stays 5 and the data order is preserved. Push into an empty FIFO in a tick cycle → that strobe is 0x80 with `underrun`=1, and the next strobe carries the pushed value.
- **Sticky underrun and low water.** `clr_underrun` in the same cycle as an underrun tick → `underrun` stays 1. `clr_underrun` alone → 0 next cycle. With `LOW_WATER`=64, `level` crossing 64→63 → `low_water` is 1 one cycle later.
- **Divider change and async reset.** With `cnt`=100 and `div` changed from 500 to 10 → a tick on the next edge, then period 11. Assert `rst` mid-stream at `level`=40 → outputs at reset values immediately, and `level`=0 after release.
